// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake and data bundle around the decode-stage
// immediate generator.
//   upstream   : in_valid, in_ready, in_instr[31:0], in_tag[TAG_W-1:0], flush
//   downstream : out_valid, out_ready, out_imm[IMM_W-1:0], out_fmt[2:0],
//                out_illegal, out_tag[TAG_W-1:0]
// The slave modport is the generator; the master modport is whoever drives
// instructions in and consumes results.
interface imm_gen_pipe_if #(
  parameter int IMM_W = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [IMM_W-1:0] out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_instr, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport master (
    output in_valid, in_instr, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I immediate generator for the decode stage.
// Decodes the opcode into a format class (R/I/S/B/U/J/illegal), builds the
// immediate, extends it to 32 bits and keeps the IMM_W LSBs. One register
// stage with a valid/ready handshake; flush drops both the held result and
// the word being offered in the same cycle.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : imm_gen_pipe_if.slave (handshake, instruction, tag, results)
module imm_gen_pipe #(
  parameter int IMM_W      = 32,
  parameter bit SIGN_EXT   = 1'b1,
  parameter bit SHAMT_MASK = 1'b1,
  parameter int TAG_W      = 8
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0]      instr;
  logic [6:0]       opcode;
  logic             sx;
  logic [31:0]      ext32;
  logic [2:0]       fmt_d;
  logic             ill_d;

  logic             valid_q;
  logic [IMM_W-1:0] imm_q;
  logic [2:0]       fmt_q;
  logic             ill_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             xfer;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  // Fill bit for the upper immediate bits: the format's MSB is always instr[31].
  assign sx     = SIGN_EXT ? instr[31] : 1'b0;

  always_comb begin
    ext32 = 32'd0;
    fmt_d = FMT_R;
    ill_d = 1'b0;
    unique case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        fmt_d = FMT_I;
        // Shift-immediates carry only a 5-bit shamt; funct7 lives in [31:25].
        if (SHAMT_MASK && (opcode == 7'b0010011) &&
            ((instr[14:12] == 3'b001) || (instr[14:12] == 3'b101)))
          ext32 = {27'd0, instr[24:20]};
        else
          ext32 = {{20{sx}}, instr[31:20]};
      end
      7'b0100011: begin
        fmt_d = FMT_S;
        ext32 = {{20{sx}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        fmt_d = FMT_B;
        ext32 = {{19{sx}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt_d = FMT_U;
        ext32 = {instr[31:12], 12'd0};
      end
      7'b1101111: begin
        fmt_d = FMT_J;
        ext32 = {{11{sx}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      7'b0110011: begin
        fmt_d = FMT_R;
      end
      default: begin
        fmt_d = FMT_ILL;
        ill_d = 1'b1;
      end
    endcase
  end

  assign bus.in_ready = !valid_q || bus.out_ready || bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  // Data registers only move on a kept accept, so an idle or undriven
  // in_instr never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q <= '0;
      fmt_q <= 3'd0;
      ill_q <= 1'b0;
      tag_q <= '0;
    end else if (accept && !bus.flush) begin
      imm_q <= ext32[IMM_W-1:0];
      fmt_q <= fmt_d;
      ill_q <= ill_d;
      tag_q <= bus.in_tag;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_fmt     = fmt_q;
  assign bus.out_illegal = ill_q;
  assign bus.out_tag     = tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives two generators in lockstep, one with default
// parameters (IMM_W=32, sign-extend, shamt masking) and one with IMM_W=12,
// zero-extend and no shamt masking. Expected values come from a decode
// reference written with plain arithmetic, a hand-computed vector table and
// a few directed sequences (backpressure, flush, asynchronous reset).
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  imm_gen_pipe_if #(.IMM_W(32), .TAG_W(8)) a ();
  imm_gen_pipe_if #(.IMM_W(12), .TAG_W(8)) b ();

  imm_gen_pipe #(.IMM_W(32), .SIGN_EXT(1'b1), .SHAMT_MASK(1'b1), .TAG_W(8))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  imm_gen_pipe #(.IMM_W(12), .SIGN_EXT(1'b0), .SHAMT_MASK(1'b0), .TAG_W(8))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pipeline model state
  bit          mv;
  logic [31:0] ma_imm, mb_imm;
  logic [2:0]  ma_fmt, mb_fmt;
  bit          ma_ill, mb_ill;
  logic [7:0]  m_tag;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm_a;
    logic [2:0]  fmt;
    bit          ill;
    logic [31:0] imm_b;
    logic [2:0]  fmt_b;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode: assemble the field value numerically, then apply
  // two's-complement sign handling and mask to the output width.
  task automatic ref_dec(input logic [31:0] i, input int imm_w, input bit sxt,
                         input bit shm, output logic [31:0] imm,
                         output logic [2:0] fmt, output bit ill);
    longint v;
    int     nbits;
    v = 0; nbits = 0; fmt = 3'd0; ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: begin
        fmt = 3'd1;
        if (shm && i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5)) begin
          v = longint'(i[24:20]);
        end else begin
          v = longint'(i[31:20]); nbits = 12;
        end
      end
      7'h23: begin
        fmt = 3'd2; nbits = 12;
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
      end
      7'h63: begin
        fmt = 3'd3; nbits = 13;
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
            longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4;
        v = longint'(i[31:12]) * 4096;
      end
      7'h6F: begin
        fmt = 3'd5; nbits = 21;
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
            longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
      7'h33: fmt = 3'd0;
      default: begin
        fmt = 3'd7; ill = 1'b1;
      end
    endcase
    if (sxt && nbits > 0 && v >= (longint'(1) << (nbits - 1)))
      v = v - (longint'(1) << nbits);
    v = v & ((longint'(1) << imm_w) - 1);
    imm = v[31:0];
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [7:0] tg,
                       input bit fl, input bit ordy);
    a.in_valid = v; a.in_instr = ins; a.in_tag = tg; a.flush = fl; a.out_ready = ordy;
    b.in_valid = v; b.in_instr = ins; b.in_tag = tg; b.flush = fl; b.out_ready = ordy;
  endtask

  task automatic check_outputs();
    chk("out_valid_a", a.out_valid, mv);
    chk("out_valid_b", b.out_valid, mv);
    if (mv) begin
      chk("imm_a", a.out_imm, ma_imm);
      chk("fmt_a", a.out_fmt, ma_fmt);
      chk("ill_a", a.out_illegal, ma_ill);
      chk("tag_a", a.out_tag, m_tag);
      chk("imm_b", b.out_imm, mb_imm);
      chk("fmt_b", b.out_fmt, mb_fmt);
      chk("ill_b", b.out_illegal, mb_ill);
      chk("tag_b", b.out_tag, m_tag);
    end
  endtask

  // One clock: called #1 after a rising edge; returns #1 after the next one.
  task automatic cyc(input bit v, input logic [31:0] ins, input logic [7:0] tg,
                     input bit fl, input bit ordy);
    bit exp_rdy, acc;
    logic [31:0] ia, ib;
    logic [2:0]  fa, fb;
    bit la, lb;
    drive(v, ins, tg, fl, ordy);
    #1;
    exp_rdy = !mv || ordy || fl;
    chk("in_ready_a", a.in_ready, exp_rdy);
    chk("in_ready_b", b.in_ready, exp_rdy);
    acc = v && exp_rdy;
    ref_dec(ins, 32, 1'b1, 1'b1, ia, fa, la);
    ref_dec(ins, 12, 1'b0, 1'b0, ib, fb, lb);
    @(posedge clk);
    if (fl) mv = 1'b0;
    else if (acc) begin
      mv = 1'b1;
      ma_imm = ia; ma_fmt = fa; ma_ill = la;
      mb_imm = ib; mb_fmt = fb; mb_ill = lb;
      m_tag = tg;
    end else if (mv && ordy) mv = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    logic [31:0] rnd;
    logic [6:0]  opc;
    logic [6:0]  pool[11];
    errors = 0; checks = 0; mv = 1'b0;
    ma_imm = 0; mb_imm = 0; ma_fmt = 0; mb_fmt = 0; ma_ill = 0; mb_ill = 0; m_tag = 0;
    pool = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    //                instr         imm_a         fmt  ill  imm_b      fmt_b
    vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h0FFF, 3'd1};
    vecs[1] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 32'h0FFC, 3'd2};
    vecs[2] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 32'h0FFC, 3'd3};
    vecs[3] = '{32'h0010006F, 32'h00000800, 3'd5, 1'b0, 32'h0800, 3'd5};
    vecs[4] = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0, 32'h0000, 3'd4};
    vecs[5] = '{32'h00500113, 32'h00000005, 3'd1, 1'b0, 32'h0005, 3'd1};
    vecs[6] = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1, 32'h0000, 3'd7};
    vecs[7] = '{32'h4030D093, 32'h00000003, 3'd1, 1'b0, 32'h0403, 3'd1};
    vecs[8] = '{32'h003100B3, 32'h00000000, 3'd0, 1'b0, 32'h0000, 3'd0};
    vecs[9] = '{32'h00000000, 32'h00000000, 3'd7, 1'b1, 32'h0000, 3'd7};

    // power-on reset
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", a.out_valid, 1'b0);
    chk("rst_imm", a.out_imm, 32'h0);
    chk("rst_fmt", a.out_fmt, 3'd0);
    chk("rst_ready", a.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table, streamed back to back with out_ready=1
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, vecs[k].instr, 8'(k + 8'h40), 1'b0, 1'b1);
      chk("tbl_valid", a.out_valid, 1'b1);
      chk("tbl_imm_a", a.out_imm, vecs[k].imm_a);
      chk("tbl_fmt_a", a.out_fmt, vecs[k].fmt);
      chk("tbl_ill_a", a.out_illegal, vecs[k].ill);
      chk("tbl_imm_b", b.out_imm, vecs[k].imm_b);
      chk("tbl_fmt_b", b.out_fmt, vecs[k].fmt_b);
    end
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b1);
    chk("drain_valid", a.out_valid, 1'b0);

    // backpressure: held result stays put while a new word waits
    cyc(1'b1, 32'h00500113, 8'h11, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'hFFF00093, 8'h22, 1'b0, 1'b0);
      chk("bp_ready", a.in_ready, 1'b0);
      chk("bp_imm", a.out_imm, 32'h5);
      chk("bp_fmt", a.out_fmt, 3'd1);
      chk("bp_tag", a.out_tag, 8'h11);
    end
    cyc(1'b1, 32'hFFF00093, 8'h22, 1'b0, 1'b1);
    chk("bp_release_imm", a.out_imm, 32'hFFFFFFFF);
    chk("bp_release_tag", a.out_tag, 8'h22);

    // flush with a simultaneous valid input while holding a result
    cyc(1'b1, 32'h00500113, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 32'h123452B7, 8'h44, 1'b1, 1'b0);
    chk("flush_valid", a.out_valid, 1'b0);
    cyc(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    chk("flush_stays_empty", a.out_valid, 1'b0);

    // asynchronous reset while a result is held
    cyc(1'b1, 32'h00500113, 8'h55, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    mv = 1'b0;
    chk("arst_valid", a.out_valid, 1'b0);
    chk("arst_imm", a.out_imm, 32'h0);
    chk("arst_tag", a.out_tag, 8'h0);
    chk("arst_fmt", a.out_fmt, 3'd0);
    chk("arst_ready", a.in_ready, 1'b1);
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom();
      opc = pool[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) opc = rnd[6:0];
      ins = {rnd[31:7], opc};
      cyc($urandom_range(0, 3) != 0, ins, 8'($urandom()),
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
